// File: rtl/ramp_sequencer.sv
// ramp_sequencer: queues {target, step, hold} commands and paces a rate_limiter through them.
// Define RAMP_TIMEOUT_EN to drop commands that fail to settle within 64 ticks.
module ramp_sequencer #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [5:0]               cmd_target,
    input  logic [2:0]               cmd_step,
    input  logic [7:0]               cmd_hold,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic                     abort,
    output logic [5:0]               lim_d_in,
    output logic [2:0]               lim_step,
    input  logic [5:0]               lim_d_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RAMP, DWELL} state_t;

    state_t            state, state_nx;
    logic [16:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [16:0]       head;
    logic [5:0]        cur_target;
    logic [2:0]        cur_step;
    logic [7:0]        dwell;
    logic [DIV_W-1:0]  presc;
    logic              push, pop, empty, tick, settled, expired;

    assign cmd_ready = level != (AW+1)'(DEPTH);
    assign empty     = level == '0;
    assign push      = cmd_valid && cmd_ready && !abort;
    assign head      = mem[rd_ptr];
    assign tick      = state != IDLE && presc == cfg_div;
    assign settled   = lim_d_out == cur_target;
    assign busy      = state != IDLE;

`ifdef RAMP_TIMEOUT_EN
    logic [6:0] tmo;
    assign expired = state == RAMP && tmo[6] && !settled;
    assign err     = expired && !abort;
    always_ff @(posedge clk or posedge rst)
        if (rst) tmo <= '0;
        else tmo <= pop ? '0 : (state == RAMP && tick && !tmo[6]) ? tmo + 7'd1 : tmo;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        done     = 1'b0;
        lim_step = '0;
        if (abort) state_nx = IDLE;
        else case (state)
            IDLE: begin
                pop      = !empty;
                state_nx = empty ? IDLE : RAMP;
            end
            RAMP: begin
                if (settled) state_nx = DWELL;
                else if (expired) begin
                    pop      = !empty;
                    state_nx = empty ? IDLE : RAMP;
                end
                else lim_step = tick ? cur_step : 3'd0;
            end
            default: begin
                if (dwell == '0) begin
                    done     = 1'b1;
                    pop      = !empty;
                    state_nx = empty ? IDLE : RAMP;
                end
            end
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {cmd_target, cmd_step, cmd_hold};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            cur_target <= '0;
            cur_step   <= '0;
            dwell      <= '0;
            presc      <= '0;
            lim_d_in   <= '0;
        end else begin
            state <= state_nx;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
                rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
                level  <= level + (AW+1)'(push) - (AW+1)'(pop);
            end
            // abort freezes the limiter by pointing it at where it already is
            lim_d_in   <= abort ? lim_d_out : pop ? head[16:11] : lim_d_in;
            cur_target <= pop ? head[16:11] : cur_target;
            cur_step   <= !pop ? cur_step : (head[10:8] == 3'd0) ? 3'd1 : head[10:8];
            dwell      <= pop ? head[7:0] : (state == DWELL && tick && dwell != '0) ? dwell - 8'd1 : dwell;
            presc      <= (pop || tick || state == IDLE) ? '0 : presc + DIV_W'(1);
        end
    end
endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: directed vectors for ramp_sequencer driving a behavioural rate_limiter.
module tb_ramp_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [5:0] cmd_target = '0;
    logic [2:0] cmd_step = '0;
    logic [7:0] cmd_hold = '0;
    logic [7:0] cfg_div = '0;
    logic       abort = 1'b0;
    logic       cmd_ready, busy, done, err;
    logic [5:0] lim_d_in, lim_d_out;
    logic [2:0] lim_step;
    logic [2:0] level;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        int v, t, s, h;
        int e_step, e_din, e_busy, e_done, e_level;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    ramp_sequencer #(.DEPTH(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_hold(cmd_hold),
        .cfg_div(cfg_div), .abort(abort), .lim_d_in(lim_d_in), .lim_step(lim_step),
        .lim_d_out(lim_d_out), .busy(busy), .done(done), .err(err), .level(level)
    );

    function automatic logic [5:0] lim_next(input int d, input int o, input int s);
        if (s == 0) return 6'(o);
        if (d > o) return 6'((o + s > d) ? d : o + s);
        return 6'((o - s < d) ? d : o - s);
    endfunction

    // downstream rate_limiter: registers on the step pulse, clamps at d_in
    always_ff @(posedge clk or posedge rst)
        if (rst) lim_d_out <= '0;
        else lim_d_out <= lim_next(int'(lim_d_in), int'(lim_d_out), int'(lim_step));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int din, input int b,
                           input int d, input int lv, input int rdy);
        chk({tag, "_lim_step"}, int'(lim_step), st);
        chk({tag, "_lim_d_in"}, int'(lim_d_in), din);
        chk({tag, "_busy"}, int'(busy), b);
        chk({tag, "_done"}, int'(done), d);
        chk({tag, "_level"}, int'(level), lv);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), rdy);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    task automatic step_in(input int v, input int t, input int s, input int h, input int a);
        @(negedge clk);
        cmd_valid  = v[0];
        cmd_target = 6'(t);
        cmd_step   = 3'(s);
        cmd_hold   = 8'(h);
        abort      = a[0];
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg[5];
        int w;
        tg = '{30, 20, 21, 21, 63};

        // basic ramp {40,5,0} at cfg_div=0
        tbl[0]  = '{1, 40, 5, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 2; i <= 9; i++) tbl[i] = '{0, 0, 0, 0, 5, 40, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 40, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 40, 1, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 40, 0, 0, 0};

        do_reset();
        chk_out("reset", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 13; i++) begin
            step_in(tbl[i].v, tbl[i].t, tbl[i].s, tbl[i].h, 0);
            chk_out($sformatf("basic%0d", i), tbl[i].e_step, tbl[i].e_din,
                    tbl[i].e_busy, tbl[i].e_done, tbl[i].e_level, 1);
        end

        // pacing: cfg_div=3, {8,2,2}
        do_reset();
        cfg_div = 8'd3;
        for (int c = 0; c < 28; c++) begin
            step_in(c == 0 ? 1 : 0, 8, 2, 2, 0);
            chk_out($sformatf("pace%0d", c),
                    (c == 5 || c == 9 || c == 13 || c == 17) ? 2 : 0,
                    c >= 2 ? 8 : 0, (c >= 2 && c <= 26) ? 1 : 0,
                    c == 26 ? 1 : 0, c == 1 ? 1 : 0, 1);
        end

        // queue: fill to 4 while the first ramps, fifth held off, completion order
        do_reset();
        cfg_div = 8'd0;
        step_in(1, 30, 3, 0, 0); chk_out("q0", 0, 0, 0, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("q1", 0, 0, 0, 0, 1, 1);
        step_in(1, 20, 5, 0, 0); chk_out("q2", 3, 30, 1, 0, 0, 1);
        step_in(1, 21, 0, 0, 0); chk_out("q3", 3, 30, 1, 0, 1, 1);
        step_in(1, 21, 7, 1, 0); chk_out("q4", 3, 30, 1, 0, 2, 1);
        step_in(1, 63, 7, 0, 0); chk_out("q5", 3, 30, 1, 0, 3, 1);
        step_in(1, 1, 1, 0, 0);  chk_out("q6_full", 3, 30, 1, 0, 4, 0);
        step_in(1, 1, 1, 0, 0);  chk_out("q7_full", 3, 30, 1, 0, 4, 0);
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!done && w < 200) begin
                step_in(0, 0, 0, 0, 0);
                w++;
            end
            chk($sformatf("q_done_seen%0d", k), int'(done), 1);
            chk($sformatf("q_order%0d", k), int'(lim_d_in), tg[k]);
            step_in(0, 0, 0, 0, 0);
            chk($sformatf("q_no_bubble%0d", k), int'(busy), k < 4 ? 1 : 0);
        end

        // abort mid-ramp toward 60 with two queued and a push in the abort cycle
        do_reset();
        step_in(1, 60, 3, 0, 0); chk_out("ab0", 0, 0, 0, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("ab1", 0, 0, 0, 0, 1, 1);
        step_in(1, 5, 1, 0, 0);  chk_out("ab2", 3, 60, 1, 0, 0, 1);
        step_in(1, 6, 1, 0, 0);  chk_out("ab3", 3, 60, 1, 0, 1, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("ab4", 3, 60, 1, 0, 2, 1);
        step_in(1, 7, 1, 0, 1);  chk_out("ab5", 0, 60, 1, 0, 2, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("ab6", 0, 9, 0, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("ab7", 0, 9, 0, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("ab8", 0, 9, 0, 0, 0, 1);

        // already settled, then a step-0 command ramps by 1
        step_in(1, 9, 0, 0, 0);  chk_out("st0", 0, 9, 0, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st1", 0, 9, 0, 0, 1, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st2", 0, 9, 1, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st3", 0, 9, 1, 1, 0, 1);
        step_in(1, 12, 0, 0, 0); chk_out("st4", 0, 9, 0, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st5", 0, 9, 0, 0, 1, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st6", 1, 12, 1, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st7", 1, 12, 1, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st8", 1, 12, 1, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st9", 0, 12, 1, 0, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st10", 0, 12, 1, 1, 0, 1);
        step_in(0, 0, 0, 0, 0);  chk_out("st11", 0, 12, 0, 0, 0, 1);

        // asynchronous reset mid-ramp with entries queued
        do_reset();
        step_in(1, 60, 3, 0, 0);
        step_in(0, 0, 0, 0, 0);
        step_in(1, 5, 1, 0, 0);
        step_in(1, 6, 1, 0, 0);
        step_in(0, 0, 0, 0, 0);  chk_out("pre_rst", 3, 60, 1, 0, 2, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_out("rst_async", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        step_in(0, 0, 0, 0, 0);  chk_out("post_rst", 0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ramp_sequencer.md
# ramp_sequencer

- Command-driven controller that sequences a downstream 6-bit `rate_limiter` through a queue of setpoints.
- Each queued command carries a target, a step size and a dwell time. The block feeds the target and step to the limiter, paces its updates with a programmable tick, and waits for the limiter output to settle. It then dwells for the commanded time and signals completion before issuing the next command.
- It sits between a host/register-file command source and the `rate_limiter` instance.

## Interface
- `DEPTH`, 4: command FIFO depth; power of 2, at least 2.
- `DIV_W`, 8: width of the tick prescaler divisor.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full; equals `!full`, combinational.
- `cmd_target`  in  6  setpoint, 0..63.
- `cmd_step`  in  3  step size; 0 is treated as 1.
- `cmd_hold`  in  8  dwell length in ticks after the target is reached.
- `cfg_div`  in  DIV_W  tick period minus 1; sampled live.
- `abort`  in  1  single-cycle pulse; flush the queue and stop.
- `lim_d_in`  out  6  drives the limiter `d_in`.
- `lim_step`  out  3  drives the limiter `step_size`; 0 except on tick cycles.
- `lim_d_out`  in  6  limiter `d_out` feedback.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a command completes its dwell.
- `err`  out  1  one-cycle pulse on ramp timeout (see Configuration).
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO**
  - A push occurs on `cmd_valid && cmd_ready` and stores {target, step, hold}.
  - A pop occurs when the FSM loads a command.
  - Push and pop in the same cycle leave `level` unchanged.
  - Pointers wrap modulo DEPTH.
- **IDLE**
  - `lim_step`=0.
  - If the FIFO is non-empty, pop into `cur_target`, `cur_step`, `cur_hold`, set `lim_d_in`=`cur_target`, clear the prescaler and timeout counter, and go to RAMP.
- **RAMP**
  - The prescaler increments each cycle. A tick occurs when prescaler == `cfg_div`; the prescaler then clears.
  - `lim_step` = `cur_step` on a tick cycle, otherwise 0.
  - When `lim_d_out` == `cur_target`, go to DWELL with dwell counter = `cur_hold`. This check happens every cycle, including the load cycle if the output is already at target.
- **DWELL**
  - `lim_step`=0.
  - The prescaler keeps running, and each tick decrements the dwell counter.
  - When the counter is 0, pulse `done`. Then pop the next command directly, going to RAMP with the same actions as IDLE, or go to IDLE if the FIFO is empty.
  - `cur_hold`=0 gives `done` on the cycle after DWELL entry.
- **abort**
  - In any state: FIFO cleared, `lim_d_in` <= `lim_d_out` to freeze the limiter, `lim_step`=0, next state IDLE, no `done`.
  - A push in the same cycle as `abort` is discarded.
- **Reset values**
  - `lim_d_in`=0, `lim_step`=0, `busy`=0, `done`=0, `err`=0, `level`=0.
  - `cmd_ready`=1 as soon as `rst` deasserts.
  - All counters are 0 and the state is IDLE.
  - Asserting `rst` mid-ramp forces these values immediately, without waiting for a clock edge.

## Timing
- Accept-to-RAMP latency:
  - FIFO empty and state IDLE: command accepted at edge N, FSM pops at edge N+1, `lim_d_in` and `busy` valid after edge N+1.
- Tick spacing: `cfg_div`+1 cycles. The first tick in RAMP comes `cfg_div`+1 cycles after RAMP entry. `cfg_div`=0 gives a tick every cycle.
- The limiter registers on the tick edge, so `lim_d_out` moves one cycle after the `lim_step` pulse. Settle detection therefore lags the final tick by 1 cycle.
- `done` asserts for exactly 1 cycle.
- Back-to-back commands: the pop happens in the same cycle as `done`, with no IDLE bubble.
- `cfg_div` changes take effect at the next prescaler comparison. The block does not re-synchronise the prescaler.

## Configuration
- `RAMP_TIMEOUT_EN` defined:
  - A 7-bit timeout counter counts ticks in RAMP.
  - When it reaches 64 ticks without settling, the block pulses `err` for 1 cycle, drops the command (no `done`), and leaves `lim_d_in` at the target.
  - It then pops the next command or goes to IDLE.
- Not defined:
  - No timeout counter; `err` is tied to 0.
  - RAMP waits indefinitely.

## Test plan
- Basic ramp:
  - Stimulus: after reset, `cfg_div`=0, command {40, 5, 0}, limiter starting at 0.
  - Required: `lim_step`=5 on every RAMP cycle; `lim_d_out` steps 5,10,…,35,40; `done` pulses 1 cycle after settling; `busy` returns to 0.
- Pacing:
  - Stimulus: `cfg_div`=3, command {8, 2, 2}.
  - Required: `lim_step` pulses every 4th cycle, 4 pulses to reach 8, then 2 dwell ticks (8 cycles) before `done`.
- Queue:
  - Stimulus: push 4 commands while the first ramps.
  - Required: `cmd_ready`=0 at `level`=4; the fifth `cmd_valid` is held off; commands complete in order with no IDLE cycle between `done` and the next RAMP.
- Abort:
  - Stimulus: `abort` mid-ramp from 0 toward 60, step 3, with 2 entries queued.
  - Required: `level`=0, `lim_d_in` equals `lim_d_out` at abort time, no `done`, IDLE on the next cycle.
- Already settled / step 0:
  - Stimulus: command {`lim_d_out`, 0, 0}.
  - Required: no `lim_step` pulse and `done` within 2 cycles of the pop. A subsequent step-0 command to a new target ramps by 1 per tick.
- Timeout (`RAMP_TIMEOUT_EN`):
  - Stimulus: tie `lim_d_out`=0, command {10, 1, 0}.
  - Required: `err` pulses after 64 ticks, no `done`, next command loaded.
- Reset mid-ramp:
  - Stimulus: assert `rst` asynchronously mid-ramp.
  - Required: all outputs at reset values immediately.
